seq_multiplier_signed: RTL and testbench
========================================

Name: seq_multiplier_signed

Overview:
Parametrised sequential shift-add multiplier for signed (two's complement) or unsigned operands, selected per operation.
- Start/busy/ready handshake; result register holds the product between operations.
- Handles sign in sign-magnitude: magnitudes are multiplied, then the product is negated when operand signs differ.
- Sits beside the arithmetic datapath as the area-cheap multiplier of the multi-cycle ALU.

Parameters:
WORD_LENGTH, 8, operand width in bits (≥2)
CNT_BITS, $clog2(WORD_LENGTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; captured with operands
Multiplier  input  WORD_LENGTH  multiplier operand; captured on accepted start
Multiplicand  input  WORD_LENGTH  multiplicand operand; captured on accepted start
busy  output  1  high from accepted start until ready cycle inclusive
ready  output  1  one-cycle pulse: Product valid and updated
Product  output  2*WORD_LENGTH  registered result, held until next completion

Behaviour:
- Reset (async, high): state IDLE, busy=0, ready=0, Product=0, internal registers cleared.
- States: IDLE -> LOAD on start=1; LOAD -> CALC; CALC -> DONE when counter reaches WORD_LENGTH-1 (i.e. after WORD_LENGTH CALC cycles); DONE -> IDLE.
- IDLE: start accepted; operands and signed_mode captured that edge.
- LOAD (1 cycle):
  - Compute magnitudes: in signed mode, negate an operand whose MSB=1; in unsigned mode, pass through. Magnitudes are WORD_LENGTH-bit unsigned, so the most negative value maps to 2^(W-1) correctly.
  - neg_flag = signed_mode & (sign_mplier ^ sign_mcand).
  - Clear accumulator and counter.
- CALC (per cycle):
  - If multiplier-register LSB=1, add the zero-extended 2W-bit multiplicand register to the accumulator.
  - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
- DONE: Product <= neg_flag ? two's-complement negate of accumulator (2W bits) : accumulator; ready=1 for this cycle only.
- Latency: start accepted at edge N; ready high in the cycle after edge N+WORD_LENGTH+1, i.e. WORD_LENGTH+2 cycles. Next start is accepted in the cycle after ready.
- busy = (state != IDLE), combinational from state register; ready likewise from state.
- start while busy: ignored, no queuing; operands not re-captured.
- Zero product with neg_flag set: negation of 0 yields 0 (no negative zero).
- Accumulator width 2W; no overflow possible for unsigned, or signed magnitudes ≤ 2^(W-1).
- Reset mid-operation: immediate abort to IDLE, Product=0, no ready pulse.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
Macro SEQ_MULT_EARLY_TERM_EN.
- Defined: in CALC, if the multiplier shift register (after the current shift) is all-zero, go to DONE next edge. Minimum latency is 3 cycles (multiplier magnitude 0: LOAD, one CALC, DONE). Results are identical to the non-early case.
- Undefined: fixed WORD_LENGTH CALC cycles always; deterministic latency.

Decomposition:
- Shared package seq_arith_pkg:
  - State encoding localparams (IDLE=0, LOAD=1, CALC=2, DONE=3), 2-bit state type.
  - Helper function for two's-complement magnitude.
- One sub-module is natural: seq_mult_datapath (magnitude conversion, shift registers, accumulator, final negate), controlled by the FSM top.
- The counter stays inline.

Test Plan:
- W=8, signed_mode=1, Multiplier=3, Multiplicand=0xFB (-5) -> Product=0xFFF1 (-15), ready pulse exactly 10 cycles after start edge, busy high 10 cycles.
- W=8, signed 0x80*0x80 -> 0x4000; unsigned 0xFF*0xFF -> 0xFE01; signed 0xFF*0xFF -> 0x0001.
- W=8, signed 0x00*0x85 -> 0x0000 (no negative zero); ready exactly one cycle.
- Start pulsed during CALC with different operands -> ignored; first result correct; back-to-back start on the cycle after ready accepted.
- Reset asserted mid-CALC -> busy=0, Product=0 asynchronously, no ready; next operation (7*6 -> 0x002A) correct.
- With SEQ_MULT_EARLY_TERM_EN: Multiplier=1, Multiplicand=0x7F -> 0x007F, ready 3 cycles after start; without macro, ready at 10 cycles; random sweep matches reference model in both builds.

Source files
------------

// File: rtl/seq_arith_pkg.sv
// Shared types and helpers for the sequential arithmetic units.
// State encoding is fixed so waveforms read the same across units.
package seq_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Conditional two's-complement negate; callers truncate to their own width,
    // so the most negative operand comes back as its unsigned magnitude.
    function automatic logic [63:0] twos_mag(input logic [63:0] v, input logic is_neg);
        return is_neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/seq_multiplier_signed_if.sv
// Operand/result bundle of the sequential multiplier.
// master drives operands and start; slave returns busy, ready and Product.
interface seq_multiplier_signed_if #(
    parameter int WORD_LENGTH = 8
);
    logic                       start;
    logic                       signed_mode;
    logic [WORD_LENGTH-1:0]     Multiplier;
    logic [WORD_LENGTH-1:0]     Multiplicand;
    logic                       busy;
    logic                       ready;
    logic [2*WORD_LENGTH-1:0]   Product;

    modport master (
        output start, signed_mode, Multiplier, Multiplicand,
        input  busy, ready, Product
    );

    modport slave (
        input  start, signed_mode, Multiplier, Multiplicand,
        output busy, ready, Product
    );
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: operand capture, magnitude conversion, accumulate, sign fix-up.
// One add per calc cycle; Product is written on the last calc edge, so it is valid while ready is high.
// No backpressure of its own; sequenced entirely by the controlling FSM.
module seq_mult_datapath
    import seq_arith_pkg::*;
#(
    parameter int WORD_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       capture,
    input  logic                       load,
    input  logic                       calc,
    input  logic                       finish,
    input  logic                       signed_mode,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    output logic                       mplier_done,
    output logic [2*WORD_LENGTH-1:0]   product
);
    localparam int W = WORD_LENGTH;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           sm_q;
    logic           neg_flag;
    logic [W-1:0]   mplier_sr;
    logic [2*W-1:0] mcand_sr;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_sum;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;

    always_comb begin
        mag_a       = W'(twos_mag(64'(op_a), sm_q & op_a[W-1]));
        mag_b       = W'(twos_mag(64'(op_b), sm_q & op_b[W-1]));
        acc_sum     = mplier_sr[0] ? (acc + mcand_sr) : acc;
        // Multiplier exhausted once the bits left after this cycle's shift are all zero.
        mplier_done = (mplier_sr[W-1:1] == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            sm_q      <= 1'b0;
            neg_flag  <= 1'b0;
            mplier_sr <= '0;
            mcand_sr  <= '0;
            acc       <= '0;
            product   <= '0;
        end else begin
            if (capture) begin
                op_a <= multiplier;
                op_b <= multiplicand;
                sm_q <= signed_mode;
            end
            if (load) begin
                mplier_sr <= mag_a;
                mcand_sr  <= {{W{1'b0}}, mag_b};
                acc       <= '0;
                neg_flag  <= sm_q & (op_a[W-1] ^ op_b[W-1]);
            end
            if (calc) begin
                acc       <= acc_sum;
                mcand_sr  <= {mcand_sr[2*W-2:0], 1'b0};
                mplier_sr <= {1'b0, mplier_sr[W-1:1]};
                if (finish) begin
                    product <= neg_flag ? -acc_sum : acc_sum;
                end
            end
        end
    end

endmodule

// File: rtl/seq_multiplier_signed.sv
// Sequential signed/unsigned shift-add multiplier (sign-magnitude), FSM controller + datapath.
// Latency WORD_LENGTH+2 cycles start-to-ready; SEQ_MULT_EARLY_TERM_EN ends CALC once the multiplier is exhausted (min 3).
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module seq_multiplier_signed
    import seq_arith_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int CNT_BITS    = $clog2(WORD_LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_multiplier_signed_if.slave bus
);
`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    state_t                state;
    logic [CNT_BITS-1:0]   cnt;
    logic                  mplier_done;
    logic                  last_calc;
    logic                  capture;

    assign capture   = (state == IDLE) && bus.start;
    assign last_calc = (state == CALC) &&
                       ((cnt == CNT_BITS'(WORD_LENGTH - 1)) || (EARLY_TERM && mplier_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) state <= LOAD;
                LOAD: begin
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    cnt <= cnt + CNT_BITS'(1);
                    if (last_calc) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.ready = (state == DONE);

    seq_mult_datapath #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_dp (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .load         (state == LOAD),
        .calc         (state == CALC),
        .finish       (last_calc),
        .signed_mode  (bus.signed_mode),
        .multiplier   (bus.Multiplier),
        .multiplicand (bus.Multiplicand),
        .mplier_done  (mplier_done),
        .product      (bus.Product)
    );

endmodule

// File: tb/tb_seq_multiplier_signed.sv
// Scoreboard bench for seq_multiplier_signed: directed corner cases plus a random sweep
// against an integer-arithmetic reference model; build with SEQ_MULT_EARLY_TERM_EN for the early-exit variant.
module tb_seq_multiplier_signed;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];
    int             t_q[$];

    int   bcount = 0;
    logic prev_ready = 1'b0;

    seq_multiplier_signed_if #(.WORD_LENGTH(W)) bus ();

    seq_multiplier_signed #(.WORD_LENGTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model_product(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x;
        longint y;
        x = (sm && a[W-1]) ? longint'(a) - (longint'(1) << W) : longint'(a);
        y = (sm && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
        return (2*W)'(x * y);
    endfunction

    function automatic int model_latency(input logic sm, input logic [W-1:0] a);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int m;
        int n;
        m = (sm && a[W-1]) ? (1 << W) - int'(a) : int'(a);
        n = 0;
        while (m > 0) begin
            n++;
            m = m >> 1;
        end
        return ((n < 1) ? 1 : n) + 2;
`else
        return W + 2 + 0 * int'(sm) + 0 * int'(a);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT flags a result.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy) bcount++;
            else          bcount = 0;
            if (prev_ready) check("ready_width", 32'(bus.ready), 32'd0);
            if (bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: product 0x%0h with no operation pending", bus.Product);
                end else begin
                    logic [2*W-1:0] e;
                    int l;
                    int t;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    t = t_q.pop_front();
                    check("product", 32'(bus.Product), 32'(e));
                    check("latency", 32'(cyc - t), 32'(l));
                    check("busy_cycles", 32'(bcount), 32'(l));
                end
            end
            prev_ready = bus.ready;
        end
    end

    task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: busy=%0b after %0d cycles, expected 0", bus.busy, n);
        end
        bus.start        = 1'b1;
        bus.signed_mode  = sm;
        bus.Multiplier   = a;
        bus.Multiplicand = b;
        exp_q.push_back(exp);
        lat_q.push_back(model_latency(sm, a));
        t_q.push_back(cyc);
        @(negedge clk);
        bus.start        = 1'b0;
        bus.signed_mode  = 1'($urandom_range(0, 1));
        bus.Multiplier   = W'($urandom);
        bus.Multiplicand = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        lat_q.delete();
        t_q.delete();
    endtask

    typedef struct {
        logic           sm;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t dir[8] = '{
        '{1'b1, 8'h03, 8'hFB, 16'hFFF1},
        '{1'b1, 8'h80, 8'h80, 16'h4000},
        '{1'b0, 8'h80, 8'h80, 16'h4000},
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
        '{1'b1, 8'hFF, 8'hFF, 16'h0001},
        '{1'b1, 8'h00, 8'h85, 16'h0000},
        '{1'b1, 8'h01, 8'h7F, 16'h007F},
        '{1'b1, 8'h7F, 8'h80, 16'hC080}
    };

    initial begin
        logic           sm;
        logic [W-1:0]   a;
        logic [W-1:0]   b;

        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.signed_mode  = 1'b0;
        bus.Multiplier   = '0;
        bus.Multiplicand = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_product", 32'(bus.Product), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (dir[i]) begin
            issue(dir[i].sm, dir[i].a, dir[i].b, dir[i].p);
            wait_idle();
        end

        // start pulsed mid-operation with different operands must be ignored
        issue(1'b1, 8'h05, 8'hF9, 16'hFFDD);
        repeat (4) @(negedge clk);
        bus.start        = 1'b1;
        bus.Multiplier   = 8'h11;
        bus.Multiplicand = 8'h22;
        @(negedge clk);
        bus.start        = 1'b0;
        wait_idle();

        // back-to-back: second start lands the cycle after ready
        issue(1'b0, 8'h0C, 8'h0D, 16'h009C);
        issue(1'b0, 8'h10, 8'h10, 16'h0100);

        // reset mid-CALC aborts the pending operation
        issue(1'b0, 8'h09, 8'h09, 16'h0051);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd0);
        check("abort_product", 32'(bus.Product), 32'd0);
        exp_q.delete();
        lat_q.delete();
        t_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b1, 8'h07, 8'h06, 16'h002A);
        wait_idle();

        for (int k = 0; k < 60; k++) begin
            sm = 1'($urandom_range(0, 1));
            a  = W'($urandom);
            b  = W'($urandom);
            if (k % 10 == 0) a = W'($urandom_range(0, 3));
            issue(sm, a, b, model_product(sm, a, b));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
